// File: rtl/blink_multirate.sv
// rtl/blink_multirate.sv - four-rate 50% duty LED blinker with glitch-free rate switch
// Optional BLINK_SYNC_EN: 2-flop synchronizers on en and sel.
module blink_multirate #(
    parameter int CNT_W = 32,
    parameter int HALF0 = 500,
    parameter int HALF1 = 1250,
    parameter int HALF2 = 2500,
    parameter int HALF3 = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sel,
    output logic       led,
    output logic       tick,
    output logic [1:0] rate_cur
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TERM0 = CNT_W'(HALF0 - 1);
    localparam logic [CNT_W-1:0] TERM1 = CNT_W'(HALF1 - 1);
    localparam logic [CNT_W-1:0] TERM2 = CNT_W'(HALF2 - 1);
    localparam logic [CNT_W-1:0] TERM3 = CNT_W'(HALF3 - 1);

    logic       en_i;
    logic [1:0] sel_i;

`ifdef BLINK_SYNC_EN
    logic [1:0] en_sync;
    logic [1:0] sel_sync0;
    logic [1:0] sel_sync1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_sync   <= 2'b00;
            sel_sync0 <= 2'b00;
            sel_sync1 <= 2'b00;
        end else begin
            en_sync   <= {en_sync[0], en};
            sel_sync0 <= sel;
            sel_sync1 <= sel_sync0;
        end
    end

    assign en_i  = en_sync[1];
    assign sel_i = sel_sync1;
`else
    assign en_i  = en;
    assign sel_i = sel;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] term;
    logic             led_nxt;
    logic             tick_nxt;
    logic [1:0]       rate_nxt;

    always_comb begin
        term = TERM0;
        case (rate_cur)
            2'd0: term = TERM0;
            2'd1: term = TERM1;
            2'd2: term = TERM2;
            2'd3: term = TERM3;
            default: term = TERM0;
        endcase
    end

    // Disable takes priority over a coincident terminal count: no toggle pulse.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        led_nxt   = led;
        tick_nxt  = 1'b0;
        rate_nxt  = rate_cur;
        if (!en_i) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            led_nxt   = 1'b0;
            rate_nxt  = sel_i;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    led_nxt   = 1'b0;
                    rate_nxt  = sel_i;
                end
                RUN: begin
                    if (cnt == term) begin
                        cnt_nxt  = '0;
                        led_nxt  = ~led;
                        tick_nxt = 1'b1;
                        rate_nxt = sel_i;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    led_nxt   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            led      <= 1'b0;
            tick     <= 1'b0;
            rate_cur <= 2'd0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            led      <= led_nxt;
            tick     <= tick_nxt;
            rate_cur <= rate_nxt;
        end
    end

endmodule

// File: tb/tb_blink_multirate.sv
// tb/tb_blink_multirate.sv - directed self-checking bench for blink_multirate
module tb_blink_multirate;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] sel;
    logic       led;
    logic       tick;
    logic [1:0] rate_cur;

    int checks   = 0;
    int failures = 0;

    blink_multirate #(
        .CNT_W(8),
        .HALF0(4),
        .HALF1(6),
        .HALF2(8),
        .HALF3(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sel      (sel),
        .led      (led),
        .tick     (tick),
        .rate_cur (rate_cur)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Edge numbers below count from the RUN entry edge (E0) after reset release.
    initial begin
        rst = 1'b0;
        en  = 1'b1;
        sel = 2'd0;
        #2 rst = 1'b1;
        #1;
        chk("reset_led", {1'b0, led}, 2'd0);
        chk("reset_tick", {1'b0, tick}, 2'd0);
        chk("reset_rate", rate_cur, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        cyc(1);
        chk("entry_led", {1'b0, led}, 2'd0);
        cyc(3);
        chk("e3_led", {1'b0, led}, 2'd0);
        cyc(1);
        chk("rise4_led", {1'b0, led}, 2'd1);
        chk("rise4_tick", {1'b0, tick}, 2'd1);
        cyc(1);
        chk("e5_tick", {1'b0, tick}, 2'd0);
        cyc(2);
        chk("e7_led", {1'b0, led}, 2'd1);
        cyc(1);
        chk("fall8_led", {1'b0, led}, 2'd0);
        chk("fall8_tick", {1'b0, tick}, 2'd1);

        cyc(1);
        sel = 2'd3;
        cyc(2);
        chk("midchg_rate_held", rate_cur, 2'd0);
        chk("midchg_led_held", {1'b0, led}, 2'd0);
        cyc(1);
        chk("e12_led", {1'b0, led}, 2'd1);
        chk("e12_rate", rate_cur, 2'd3);
        cyc(9);
        chk("e21_led", {1'b0, led}, 2'd1);
        chk("e21_tick", {1'b0, tick}, 2'd0);
        cyc(1);
        chk("e22_led", {1'b0, led}, 2'd0);
        chk("e22_tick", {1'b0, tick}, 2'd1);
        cyc(10);
        chk("e32_led", {1'b0, led}, 2'd1);

        cyc(2);
        en  = 1'b0;
        sel = 2'd1;
        cyc(1);
        chk("dis_led", {1'b0, led}, 2'd0);
        chk("dis_tick", {1'b0, tick}, 2'd0);
        cyc(1);
        chk("idle_rate", rate_cur, 2'd1);
        en = 1'b1;
        cyc(1);
        chk("reentry_led", {1'b0, led}, 2'd0);
        cyc(5);
        chk("e42_led", {1'b0, led}, 2'd0);
        cyc(1);
        chk("e43_led", {1'b0, led}, 2'd1);
        chk("e43_tick", {1'b0, tick}, 2'd1);
        chk("e43_rate", rate_cur, 2'd1);

        cyc(6);
        chk("e49_led", {1'b0, led}, 2'd0);
        chk("e49_tick", {1'b0, tick}, 2'd1);
        cyc(5);
        chk("e54_led", {1'b0, led}, 2'd0);
        en = 1'b0;
        cyc(1);
        chk("tc_dis_led", {1'b0, led}, 2'd0);
        chk("tc_dis_tick", {1'b0, tick}, 2'd0);

        cyc(1);
        en  = 1'b1;
        sel = 2'd2;
        cyc(1);
        chk("e57_rate", rate_cur, 2'd2);
        cyc(8);
        chk("e65_led", {1'b0, led}, 2'd1);
        chk("e65_tick", {1'b0, tick}, 2'd1);
        cyc(5);
        chk("pre_rst_led", {1'b0, led}, 2'd1);
        chk("pre_rst_rate", rate_cur, 2'd2);
        #1 rst = 1'b1;
        #1;
        chk("async_led", {1'b0, led}, 2'd0);
        chk("async_tick", {1'b0, tick}, 2'd0);
        chk("async_rate", rate_cur, 2'd0);
        #1 rst = 1'b0;

        cyc(1);
        chk("rerun_rate", rate_cur, 2'd2);
        cyc(7);
        chk("e78_led", {1'b0, led}, 2'd0);
        cyc(1);
        chk("e79_led", {1'b0, led}, 2'd1);
        chk("e79_tick", {1'b0, tick}, 2'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
